// File: rtl/hazard_controller_if.sv
// Hazard controller bus: ID-stage instruction info in, pipeline control out.
interface hazard_controller_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH    = 16
);
  logic                      ID_VALID;
  logic [REG_ADDR_WIDTH-1:0] ID_R1;
  logic [REG_ADDR_WIDTH-1:0] ID_R2;
  logic                      ID_USES_R1;
  logic                      ID_USES_R2;
  logic [REG_ADDR_WIDTH-1:0] ID_RD;
  logic                      ID_REG_WRITE;
  logic                      ID_IS_LOAD;
  logic                      EX_BRANCH_TAKEN;
  logic                      STALL;
  logic                      FLUSH;
  logic [1:0]                FWD_X1_SEL;
  logic [1:0]                FWD_X2_SEL;
  logic                      BYPASS_ID_R1;
  logic                      BYPASS_ID_R2;
  logic [COUNT_WIDTH-1:0]    STALL_COUNT;
  logic [COUNT_WIDTH-1:0]    FLUSH_COUNT;

  // Datapath side
  modport master (
    output ID_VALID, ID_R1, ID_R2, ID_USES_R1, ID_USES_R2, ID_RD,
           ID_REG_WRITE, ID_IS_LOAD, EX_BRANCH_TAKEN,
    input  STALL, FLUSH, FWD_X1_SEL, FWD_X2_SEL, BYPASS_ID_R1,
           BYPASS_ID_R2, STALL_COUNT, FLUSH_COUNT
  );

  // Hazard controller side
  modport slave (
    input  ID_VALID, ID_R1, ID_R2, ID_USES_R1, ID_USES_R2, ID_RD,
           ID_REG_WRITE, ID_IS_LOAD, EX_BRANCH_TAKEN,
    output STALL, FLUSH, FWD_X1_SEL, FWD_X2_SEL, BYPASS_ID_R1,
           BYPASS_ID_R2, STALL_COUNT, FLUSH_COUNT
  );
endinterface

// File: rtl/hazard_controller.sv
// Hazard scheduler for a 5-stage RV32I pipeline: scoreboard of EX/MEM/WB,
// load-use stall, branch flush, EX forwarding selects, ID regfile bypass and
// saturating stall/flush counters.
module hazard_controller #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH    = 16
) (
  input logic          CLK,
  input logic          RESET,
  hazard_controller_if.slave bus
);

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic                      uses_r1;
    logic                      uses_r2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      reg_write;
    logic                      is_load;
  } slot_t;

  slot_t ex_q, mem_q, wb_q, ex_d;
  logic  load_use_w, stall_w, flush_w;
  logic [COUNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [COUNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  // Per-operand views so forwarding/bypass logic is written once.
  logic [1:0][REG_ADDR_WIDTH-1:0] ex_src, id_src;
  logic [1:0]                     ex_use, id_use, bypass_w;
  logic [1:0][1:0]                fwd_sel_w;

  // Source fields of older slots are carried for debug visibility only.
  logic slot_fields_unused;
  assign slot_fields_unused = ^{mem_q.rs1, mem_q.rs2, mem_q.uses_r1, mem_q.uses_r2,
                                wb_q.rs1, wb_q.rs2, wb_q.uses_r1, wb_q.uses_r2,
                                wb_q.is_load};

  // A slot produces register r only if it is live, writes, and r is not x0.
  function automatic logic writes_reg(input slot_t s, input logic [REG_ADDR_WIDTH-1:0] r);
    return s.valid && s.reg_write && (s.rd == r) && (r != '0);
  endfunction

  assign ex_src = {ex_q.rs2, ex_q.rs1};
  assign ex_use = {ex_q.uses_r2, ex_q.uses_r1};
  assign id_src = {bus.ID_R2, bus.ID_R1};
  assign id_use = {bus.ID_USES_R2, bus.ID_USES_R1};

  // Load in EX feeding an operand ID reads needs one bubble; a flush wins.
  assign load_use_w = bus.ID_VALID && ex_q.is_load &&
                      ((bus.ID_USES_R1 && writes_reg(ex_q, bus.ID_R1)) ||
                       (bus.ID_USES_R2 && writes_reg(ex_q, bus.ID_R2)));
  assign flush_w = bus.EX_BRANCH_TAKEN;
  assign stall_w = load_use_w && !flush_w;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      // MEM (younger) beats WB; a MEM load is never a forwarding source.
      assign fwd_sel_w[gi] =
        !(ex_q.valid && ex_use[gi])                          ? 2'd0 :
        (writes_reg(mem_q, ex_src[gi]) && !mem_q.is_load)     ? 2'd1 :
        writes_reg(wb_q, ex_src[gi])                          ? 2'd2 : 2'd0;
      // Regfile is written at the edge, so ID sees the WB value early.
      assign bypass_w[gi] = bus.ID_VALID && id_use[gi] && writes_reg(wb_q, id_src[gi]);
    end
  endgenerate

  assign bus.STALL        = stall_w;
  assign bus.FLUSH        = flush_w;
  assign bus.FWD_X1_SEL   = fwd_sel_w[0];
  assign bus.FWD_X2_SEL   = fwd_sel_w[1];
  assign bus.BYPASS_ID_R1 = bypass_w[0];
  assign bus.BYPASS_ID_R2 = bypass_w[1];
  assign bus.STALL_COUNT  = stall_cnt_q;
  assign bus.FLUSH_COUNT  = flush_cnt_q;

  // Next EX slot: the ID instruction unless it is a bubble, stalled or flushed.
  always_comb begin
    ex_d = '0;
    if (bus.ID_VALID && !stall_w && !flush_w) begin
      ex_d.valid     = 1'b1;
      ex_d.rs1       = bus.ID_R1;
      ex_d.rs2       = bus.ID_R2;
      ex_d.uses_r1   = bus.ID_USES_R1;
      ex_d.uses_r2   = bus.ID_USES_R2;
      ex_d.rd        = bus.ID_RD;
      ex_d.reg_write = bus.ID_REG_WRITE;
      ex_d.is_load   = bus.ID_IS_LOAD;
    end
  end

  // Saturating increments for the debug counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_w && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_w && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Scoreboard shift: ID -> EX -> MEM -> WB.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
